// File: rtl/riscv_pkg.sv
// Shared definitions for the writeback path of the pipelined RISC-V core.
//   wb_sel_e   : writeback source select carried down the pipe from decode
//   F3_*       : load funct3 encodings understood by the load formatter
//   wb_state_e : MEM/WB stage sequencing states
package riscv_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4  = 2'b10
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        LOAD_WAIT = 2'b01,
        WRITE     = 2'b10
    } wb_state_e;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Signal bundle between the MEM stage / data memory and the MEM/WB stage,
// plus the register-file write port driven by the stage.
//   master : MEM stage + data memory side (drives instruction and load data)
//   slave  : MEM/WB stage (drives stall, register-file write, timeout pulse)
interface mem_wb_stage_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  mem_valid_i;
    logic [4:0]            mem_rd_addr_i;
    logic                  mem_rd_wren_i;
    logic [1:0]            mem_wb_sel_i;
    logic [2:0]            mem_funct3_i;
    logic [DATA_WIDTH-1:0] mem_alu_result_i;
    logic [DATA_WIDTH-1:0] mem_pc_plus4_i;
    logic                  dmem_rvalid_i;
    logic [DATA_WIDTH-1:0] dmem_rdata_i;
    logic                  stall_o;
    logic                  rd_wren_o;
    logic [4:0]            rd_addr_o;
    logic [DATA_WIDTH-1:0] rd_data_o;
    logic                  load_timeout_o;

    modport master (
        output mem_valid_i, mem_rd_addr_i, mem_rd_wren_i, mem_wb_sel_i,
               mem_funct3_i, mem_alu_result_i, mem_pc_plus4_i,
               dmem_rvalid_i, dmem_rdata_i,
        input  stall_o, rd_wren_o, rd_addr_o, rd_data_o, load_timeout_o
    );

    modport slave (
        input  mem_valid_i, mem_rd_addr_i, mem_rd_wren_i, mem_wb_sel_i,
               mem_funct3_i, mem_alu_result_i, mem_pc_plus4_i,
               dmem_rvalid_i, dmem_rdata_i,
        output stall_o, rd_wren_o, rd_addr_o, rd_data_o, load_timeout_o
    );

endinterface

// File: rtl/mem_wb_stage_load_align.sv
// Load formatter: picks the addressed byte/halfword out of the raw memory
// word and sign- or zero-extends it according to funct3.
//   funct3_i   : load type
//   offset_i   : byte offset within the word (load address bits [1:0])
//   raw_word_i : aligned word returned by data memory
//   word_o     : value to write back to rd
module load_align
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            funct3_i,
    input  logic [1:0]            offset_i,
    input  logic [DATA_WIDTH-1:0] raw_word_i,
    output logic [DATA_WIDTH-1:0] word_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane select; halfword loads use only offset bit 1 (bit 0 is ignored).
    always_comb begin
        byte_s = raw_word_i[{offset_i, 3'b000} +: 8];
        half_s = raw_word_i[{offset_i[1], 4'b0000} +: 16];
    end

    // Extension by load type; reserved codes behave like LW.
    always_comb begin
        word_o = raw_word_i;
        case (funct3_i)
            F3_LB:   word_o = {{(DATA_WIDTH-8){byte_s[7]}}, byte_s};
            F3_LBU:  word_o = {{(DATA_WIDTH-8){1'b0}}, byte_s};
            F3_LH:   word_o = {{(DATA_WIDTH-16){half_s[15]}}, half_s};
            F3_LHU:  word_o = {{(DATA_WIDTH-16){1'b0}}, half_s};
            default: word_o = raw_word_i;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage. Accepts one instruction per cycle from MEM, waits
// for load data when needed (stalling upstream), formats loads and drives
// the register-file write port for one cycle in WRITE.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus (slave)   : MEM-stage instruction, load response, stall, rf write
//                   port and the load-timeout pulse
module mem_wb_stage
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int LOAD_TIMEOUT = 16
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    mem_wb_stage_if.slave  bus
);

    localparam int CNT_W = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    wb_state_e             state_r;
    wb_state_e             state_nxt_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [4:0]            rd_addr_r;
    logic                  rd_wren_r;
    logic [1:0]            wb_sel_r;
    logic [2:0]            funct3_r;
    logic [1:0]            offset_r;
    logic [DATA_WIDTH-1:0] alu_r;
    logic [DATA_WIDTH-1:0] pc4_r;
    logic [DATA_WIDTH-1:0] load_data_r;
    logic                  timed_out_r;

    logic                  accept_s;
    logic                  timeout_hit_s;
    logic [DATA_WIDTH-1:0] aligned_s;
    logic [DATA_WIDTH-1:0] wb_data_s;

    load_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_load_align (
        .funct3_i   (funct3_r),
        .offset_i   (offset_r),
        .raw_word_i (bus.dmem_rdata_i),
        .word_o     (aligned_s)
    );

    // Accept and timeout qualifiers; a zero LOAD_TIMEOUT never expires.
    always_comb begin
        accept_s      = bus.mem_valid_i && (state_r != LOAD_WAIT);
        timeout_hit_s = 1'b0;
        if ((LOAD_TIMEOUT != 0) && (cnt_r == CNT_LAST)) begin
            timeout_hit_s = 1'b1;
        end else begin
            timeout_hit_s = 1'b0;
        end
    end

    // Next-state logic; load data beats the timeout when both occur.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE, WRITE: begin
                if (accept_s) begin
                    if (bus.mem_wb_sel_i == WB_LOAD) begin
                        state_nxt_s = LOAD_WAIT;
                    end else begin
                        state_nxt_s = WRITE;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOAD_WAIT: begin
                if (bus.dmem_rvalid_i || timeout_hit_s) begin
                    state_nxt_s = WRITE;
                end else begin
                    state_nxt_s = LOAD_WAIT;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Instruction capture, load-wait counter and formatted load data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_r       <= '0;
            rd_addr_r   <= 5'd0;
            rd_wren_r   <= 1'b0;
            wb_sel_r    <= 2'b00;
            funct3_r    <= 3'b000;
            offset_r    <= 2'b00;
            alu_r       <= '0;
            pc4_r       <= '0;
            load_data_r <= '0;
            timed_out_r <= 1'b0;
        end else if (accept_s) begin
            cnt_r       <= '0;
            rd_addr_r   <= bus.mem_rd_addr_i;
            rd_wren_r   <= bus.mem_rd_wren_i;
            wb_sel_r    <= bus.mem_wb_sel_i;
            funct3_r    <= bus.mem_funct3_i;
            offset_r    <= bus.mem_alu_result_i[1:0];
            alu_r       <= bus.mem_alu_result_i;
            pc4_r       <= bus.mem_pc_plus4_i;
            load_data_r <= '0;
            timed_out_r <= 1'b0;
        end else if (state_r == LOAD_WAIT) begin
            if (bus.dmem_rvalid_i) begin
                load_data_r <= aligned_s;
            end else if (timeout_hit_s) begin
                timed_out_r <= 1'b1;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

    // Writeback source mux; the reserved select code falls back to ALU.
    always_comb begin
        wb_data_s = alu_r;
        case (wb_sel_r)
            WB_LOAD: wb_data_s = load_data_r;
            WB_PC4:  wb_data_s = pc4_r;
            default: wb_data_s = alu_r;
        endcase
    end

    // Register-file port is live only in WRITE; x0 and abandoned loads never write.
    always_comb begin
        bus.stall_o        = (state_r == LOAD_WAIT);
        bus.rd_wren_o      = 1'b0;
        bus.rd_addr_o      = 5'd0;
        bus.rd_data_o      = '0;
        bus.load_timeout_o = 1'b0;
        if (state_r == WRITE) begin
            bus.rd_wren_o      = rd_wren_r && (rd_addr_r != 5'd0) && !timed_out_r;
            bus.rd_addr_o      = rd_addr_r;
            bus.rd_data_o      = wb_data_s;
            bus.load_timeout_o = timed_out_r;
        end else begin
            bus.rd_wren_o      = 1'b0;
            bus.rd_addr_o      = 5'd0;
            bus.rd_data_o      = '0;
            bus.load_timeout_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios followed by randomized traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_mem_wb_stage;
    import riscv_pkg::*;

    localparam int DW = 32;
    localparam int TO = 16;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;

    always #5 clk_i = ~clk_i;

    mem_wb_stage_if #(.DATA_WIDTH(DW)) bus ();

    mem_wb_stage #(
        .DATA_WIDTH   (DW),
        .LOAD_TIMEOUT (TO)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus.slave)
    );

    int n_total = 0;
    int n_bad   = 0;
    int stall_cnt = 0;

    // current upstream instruction (held while the stage stalls)
    logic        t_valid;
    logic [4:0]  t_rd;
    logic        t_wren;
    logic [1:0]  t_sel;
    logic [2:0]  t_f3;
    logic [31:0] t_alu;
    logic [31:0] t_pc4;

    // reference model: outstanding load plus expected outputs this cycle
    bit          m_pending;
    int          m_wait;
    logic [4:0]  m_ld_rd;
    bit          m_ld_wren;
    logic [2:0]  m_ld_f3;
    logic [1:0]  m_ld_off;
    bit          e_wren;
    bit          e_to;
    bit          e_data_known;
    logic [4:0]  e_addr;
    logic [31:0] e_data;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Load result by arithmetic: shift the lane down, mask, sign-extend via xor/sub.
    function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * int'(off))) & 32'h0000_00FF;
        h = (w >> (16 * int'(off[1]))) & 32'h0000_FFFF;
        case (f3)
            3'b000:  return (b ^ 32'h0000_0080) - 32'h0000_0080;
            3'b100:  return b;
            3'b001:  return (h ^ 32'h0000_8000) - 32'h0000_8000;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    task automatic model_reset();
        m_pending = 0; m_wait = 0;
        e_wren = 0; e_to = 0; e_data_known = 1; e_addr = 5'd0; e_data = 32'd0;
    endtask

    // What the register-file port should show in the cycle after this edge.
    task automatic model_step(input logic rv, input logic [31:0] rdata);
        e_wren = 0; e_to = 0; e_data_known = 1; e_addr = 5'd0; e_data = 32'd0;
        if (m_pending) begin
            if (rv) begin
                e_addr = m_ld_rd;
                e_wren = m_ld_wren && (m_ld_rd != 5'd0);
                e_data = fmt_load(m_ld_f3, m_ld_off, rdata);
                m_pending = 0;
            end else if (m_wait + 1 == TO) begin
                e_addr = m_ld_rd;
                e_to = 1;
                e_data_known = 0;
                m_pending = 0;
            end else begin
                m_wait++;
            end
        end else if (t_valid) begin
            if (t_sel == 2'b01) begin
                m_pending = 1; m_wait = 0;
                m_ld_rd = t_rd; m_ld_wren = t_wren; m_ld_f3 = t_f3; m_ld_off = t_alu[1:0];
            end else begin
                e_addr = t_rd;
                e_wren = t_wren && (t_rd != 5'd0);
                e_data = (t_sel == 2'b10) ? t_pc4 : t_alu;
            end
        end
    endtask

    task automatic check_outputs();
        check_eq("stall", {31'd0, bus.stall_o}, {31'd0, m_pending});
        check_eq("wren", {31'd0, bus.rd_wren_o}, {31'd0, e_wren});
        check_eq("addr", {27'd0, bus.rd_addr_o}, {27'd0, e_addr});
        if (e_data_known) check_eq("data", bus.rd_data_o, e_data);
        check_eq("timeout", {31'd0, bus.load_timeout_o}, {31'd0, e_to});
        if (bus.stall_o) stall_cnt++;
    endtask

    // One clock: drive at negedge, advance model, sample at next negedge.
    task automatic tick(input logic rv, input logic [31:0] rdata);
        bus.mem_valid_i      = t_valid;
        bus.mem_rd_addr_i    = t_rd;
        bus.mem_rd_wren_i    = t_wren;
        bus.mem_wb_sel_i     = t_sel;
        bus.mem_funct3_i     = t_f3;
        bus.mem_alu_result_i = t_alu;
        bus.mem_pc_plus4_i   = t_pc4;
        bus.dmem_rvalid_i    = rv;
        bus.dmem_rdata_i     = rdata;
        model_step(rv, rdata);
        @(posedge clk_i);
        @(negedge clk_i);
        check_outputs();
    endtask

    task automatic set_instr(input logic v, input logic [4:0] rd, input logic w, input logic [1:0] sel,
                             input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] pc4);
        t_valid = v; t_rd = rd; t_wren = w; t_sel = sel; t_f3 = f3; t_alu = alu; t_pc4 = pc4;
    endtask

    initial begin
        set_instr(1'b0, 5'd0, 1'b0, 2'b00, 3'b000, 32'd0, 32'd0);
        bus.mem_valid_i = 1'b0; bus.mem_rd_addr_i = 5'd0; bus.mem_rd_wren_i = 1'b0;
        bus.mem_wb_sel_i = 2'b00; bus.mem_funct3_i = 3'b000; bus.mem_alu_result_i = 32'd0;
        bus.mem_pc_plus4_i = 32'd0; bus.dmem_rvalid_i = 1'b0; bus.dmem_rdata_i = 32'd0;
        model_reset();
        repeat (3) @(negedge clk_i);
        check_eq("reset_stall", {31'd0, bus.stall_o}, 32'd0);
        check_eq("reset_wren", {31'd0, bus.rd_wren_o}, 32'd0);
        check_eq("reset_data", bus.rd_data_o, 32'd0);
        check_eq("reset_timeout", {31'd0, bus.load_timeout_o}, 32'd0);
        rst_ni = 1'b1;

        // back-to-back ALU writes
        stall_cnt = 0;
        set_instr(1'b1, 5'd5, 1'b1, 2'b00, 3'b000, 32'h11, 32'd0);
        tick(1'b0, 32'd0);
        check_eq("alu1_data", bus.rd_data_o, 32'h0000_0011);
        set_instr(1'b1, 5'd6, 1'b1, 2'b00, 3'b000, 32'h22, 32'd0);
        tick(1'b0, 32'd0);
        check_eq("alu2_data", bus.rd_data_o, 32'h0000_0022);
        check_eq("alu2_wren", {31'd0, bus.rd_wren_o}, 32'd1);
        t_valid = 1'b0;
        tick(1'b0, 32'd0);
        check_eq("alu_no_stall", stall_cnt, 32'd0);

        // LB offset 3, response three cycles after accept
        stall_cnt = 0;
        set_instr(1'b1, 5'd7, 1'b1, 2'b01, 3'b000, 32'h0000_1003, 32'd0);
        tick(1'b0, 32'd0);
        tick(1'b0, 32'd0);
        tick(1'b0, 32'd0);
        t_valid = 1'b0;
        tick(1'b1, 32'h80FF_1234);
        check_eq("lb_stall_cycles", stall_cnt, 32'd3);
        check_eq("lb_data", bus.rd_data_o, 32'hFFFF_FF80);

        // LHU offset 2, then LH offset 0
        set_instr(1'b1, 5'd8, 1'b1, 2'b01, 3'b101, 32'h0000_2002, 32'd0);
        tick(1'b0, 32'd0);
        t_valid = 1'b0;
        tick(1'b1, 32'h8001_7FFF);
        check_eq("lhu_data", bus.rd_data_o, 32'h0000_8001);
        set_instr(1'b1, 5'd8, 1'b1, 2'b01, 3'b001, 32'h0000_2000, 32'd0);
        tick(1'b0, 32'd0);
        t_valid = 1'b0;
        tick(1'b1, 32'h8001_7FFF);
        check_eq("lh_data", bus.rd_data_o, 32'h0000_7FFF);
        tick(1'b0, 32'd0);

        // abandoned load, then an ALU op is still accepted
        stall_cnt = 0;
        set_instr(1'b1, 5'd9, 1'b1, 2'b01, 3'b010, 32'h0000_3000, 32'd0);
        tick(1'b0, 32'd0);
        repeat (TO - 1) tick(1'b0, 32'd0);
        check_eq("to_stall_cycles", stall_cnt, 32'd16);
        tick(1'b0, 32'd0);
        check_eq("to_pulse", {31'd0, bus.load_timeout_o}, 32'd1);
        check_eq("to_no_write", {31'd0, bus.rd_wren_o}, 32'd0);
        set_instr(1'b1, 5'd10, 1'b1, 2'b00, 3'b000, 32'h55, 32'd0);
        tick(1'b0, 32'd0);
        check_eq("after_to_data", bus.rd_data_o, 32'h0000_0055);
        check_eq("after_to_pulse", {31'd0, bus.load_timeout_o}, 32'd0);

        // JAL to x0 and to x1
        set_instr(1'b1, 5'd0, 1'b1, 2'b10, 3'b000, 32'h0000_0200, 32'h0000_0104);
        tick(1'b0, 32'd0);
        check_eq("jal_x0_wren", {31'd0, bus.rd_wren_o}, 32'd0);
        set_instr(1'b1, 5'd1, 1'b1, 2'b10, 3'b000, 32'h0000_0200, 32'h0000_0104);
        tick(1'b0, 32'd0);
        check_eq("jal_x1_data", bus.rd_data_o, 32'h0000_0104);
        t_valid = 1'b0;
        tick(1'b0, 32'd0);

        // reset while a load is outstanding; late response must be dropped
        set_instr(1'b1, 5'd11, 1'b1, 2'b01, 3'b010, 32'h0000_4000, 32'd0);
        tick(1'b0, 32'd0);
        tick(1'b0, 32'd0);
        rst_ni = 1'b0;
        #1;
        model_reset();
        check_eq("rst_mid_stall", {31'd0, bus.stall_o}, 32'd0);
        check_eq("rst_mid_wren", {31'd0, bus.rd_wren_o}, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        t_valid = 1'b0;
        tick(1'b1, 32'hDEAD_BEEF);
        check_eq("rst_late_rvalid", {31'd0, bus.rd_wren_o}, 32'd0);
        tick(1'b0, 32'd0);

        // randomized traffic, including stray responses and timeouts
        for (int i = 0; i < 500; i++) begin
            if (!m_pending) begin
                set_instr(($urandom_range(0, 9) < 7), 5'($urandom_range(0, 31)),
                          1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                          3'($urandom_range(0, 7)), $urandom, $urandom);
            end
            tick(($urandom_range(0, 9) == 0), $urandom);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
